// File: rtl/exer_ram_dp_clr.sv
// exer_ram_dp_clr: true-dual-port synchronous RAM with a clear engine and write-collision arbitration.
// Build macro EXER_RAM_WRITE_FIRST_EN selects write-first read data; the default build is read-first.
module exer_ram_dp_clr #(
    parameter int unsigned   DW             = 8,
    parameter int unsigned   AW             = 11,
    parameter logic [DW-1:0] CLEAR_VAL      = '0,
    parameter bit            CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          nRESET,
    input  logic          cen,
    input  logic          clr_req,
    output logic          busy,
    output logic          wr_coll,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] data_a,
    input  logic          nWE_a,
    output logic [DW-1:0] q_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] data_b,
    input  logic          nWE_b,
    output logic [DW-1:0] q_b
);

    localparam int unsigned   DEPTH     = 2 ** AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    localparam logic [1:0] ST_RST_WAIT = 2'd0;
    localparam logic [1:0] ST_CLEAR    = 2'd1;
    localparam logic [1:0] ST_READY    = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] ctr_q, ctr_d;
    logic          busy_q, busy_d;
    logic          coll_q, coll_d;
    logic [DW-1:0] qa_q, qa_d;
    logic [DW-1:0] qb_q, qb_d;

    logic          acc_en;
    logic          we_a;
    logic          we_b;
    logic          we_b_eff;
    logic          same_addr;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;

    logic [DW-1:0] mem [DEPTH];

    // Next-state, sweep counter and registered-output logic
    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        coll_d    = 1'b0;
        qa_d      = qa_q;
        qb_d      = qb_q;
        acc_en    = (state_q == ST_READY) && cen;
        we_a      = acc_en && !nWE_a;
        we_b      = acc_en && !nWE_b;
        same_addr = (addr_a == addr_b);
        we_b_eff  = we_b && !(we_a && same_addr);
        rd_a      = mem[addr_a];
        rd_b      = mem[addr_b];

        case (state_q)
            ST_RST_WAIT: begin
                ctr_d   = '0;
                state_d = (CLEAR_ON_RESET || clr_req) ? ST_CLEAR : ST_READY;
            end
            ST_CLEAR: begin
                if (clr_req) begin
                    ctr_d = '0;
                end else if (ctr_q == LAST_ADDR) begin
                    ctr_d   = '0;
                    state_d = ST_READY;
                end else begin
                    ctr_d = ctr_q + AW'(1);
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    ctr_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                ctr_d   = '0;
                state_d = ST_RST_WAIT;
            end
        endcase

`ifdef EXER_RAM_WRITE_FIRST_EN
        // Read data reflects what actually lands in the array this cycle (port A wins a collision)
        if (we_a) begin
            rd_a = data_a;
        end else if (we_b && same_addr) begin
            rd_a = data_b;
        end
        if (we_a && same_addr) begin
            rd_b = data_a;
        end else if (we_b) begin
            rd_b = data_b;
        end
`endif

        busy_d = (state_d != ST_READY);
        if (busy_d) begin
            qa_d = CLEAR_VAL;
            qb_d = CLEAR_VAL;
        end else if (acc_en) begin
            qa_d   = rd_a;
            qb_d   = rd_b;
            coll_d = we_a && we_b && same_addr;
        end
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= ST_RST_WAIT;
            ctr_q   <= '0;
            busy_q  <= CLEAR_ON_RESET;
            coll_q  <= 1'b0;
            qa_q    <= '0;
            qb_q    <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            busy_q  <= busy_d;
            coll_q  <= coll_d;
            qa_q    <= qa_d;
            qb_q    <= qb_d;
        end
    end

    // Array storage is deliberately unreset; only the sweep defines its contents
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[ctr_q] <= CLEAR_VAL;
        end else begin
            if (we_b_eff) begin
                mem[addr_b] <= data_b;
            end
            if (we_a) begin
                mem[addr_a] <= data_a;
            end
        end
    end

    assign busy    = busy_q;
    assign wr_coll = coll_q;
    assign q_a     = qa_q;
    assign q_b     = qb_q;

endmodule
